md_unit: RTL and testbench

Parametrised multiply/divide unit holding the HI/LO register pair for the pipeline's E stage. Pipelined-latency multiply, multiply-accumulate and multiply-subtract; iterative radix-2 restoring divide with defined divide-by-zero results. Adds a cancel path for exception flush and a one-cycle `done` strobe. The pipeline stalls HI/LO readers and new md ops while `busy` is high.

---
 rtl/md_unit.sv | 200 ++++++++++++++++++++
 tb/tb_md_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: HI/LO multiply/divide unit for the E stage.
// Fixed-latency multiply/accumulate plus radix-2 restoring divide; any busy op can be cancelled.
module md_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [3:0]       op,
  input  logic             start,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CMAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_MUL      = 3'd1;
  localparam logic [2:0] S_DIV_PREP = 3'd2;
  localparam logic [2:0] S_DIV_ITER = 3'd3;
  localparam logic [2:0] S_DIV_FIX  = 3'd4;

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MADD  = 4'b0101;
  localparam logic [3:0] OP_MADDU = 4'b0110;
  localparam logic [3:0] OP_MSUB  = 4'b0111;
  localparam logic [3:0] OP_MSUBU = 4'b1000;
  localparam logic [3:0] OP_MTHI  = 4'b1001;
  localparam logic [3:0] OP_MTLO  = 4'b1010;

  logic [2:0]         state_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] res_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic               done_reg, dbz_reg;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic               sgn_reg;
  logic [WIDTH-1:0]   quo_reg, rem_reg, dvs_reg;
  logic               qneg_reg, rneg_reg, dz_reg;

  logic is_mul, is_div, mul_signed, mul_acc, mul_sub;

  always_comb begin
    is_mul     = 1'b0;
    is_div     = 1'b0;
    mul_signed = 1'b0;
    mul_acc    = 1'b0;
    mul_sub    = 1'b0;
    case (op)
      OP_MULT:  begin is_mul = 1'b1; mul_signed = 1'b1; end
      OP_MULTU: is_mul = 1'b1;
      OP_MADD:  begin is_mul = 1'b1; mul_signed = 1'b1; mul_acc = 1'b1; end
      OP_MADDU: begin is_mul = 1'b1; mul_acc = 1'b1; end
      OP_MSUB:  begin is_mul = 1'b1; mul_signed = 1'b1; mul_acc = 1'b1; mul_sub = 1'b1; end
      OP_MSUBU: begin is_mul = 1'b1; mul_acc = 1'b1; mul_sub = 1'b1; end
      OP_DIV, OP_DIVU: is_div = 1'b1;
      default: ;
    endcase
  end

  // Sign-extending to 2*WIDTH makes a plain modular multiply give the signed product.
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, acc_base, mul_result;

  always_comb begin
    ext_a      = mul_signed ? {{WIDTH{rs[WIDTH-1]}}, rs} : {{WIDTH{1'b0}}, rs};
    ext_b      = mul_signed ? {{WIDTH{rt[WIDTH-1]}}, rt} : {{WIDTH{1'b0}}, rt};
    prod       = ext_a * ext_b;
    acc_base   = mul_acc ? {hi_reg, lo_reg} : '0;
    mul_result = mul_sub ? (acc_base - prod) : (acc_base + prod);
  end

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b, q_fix, r_fix;
  logic [WIDTH:0]   rem_shift, diff;

  always_comb begin
    a_neg     = sgn_reg & a_reg[WIDTH-1];
    b_neg     = sgn_reg & b_reg[WIDTH-1];
    abs_a     = a_neg ? (~a_reg + 1'b1) : a_reg;
    abs_b     = b_neg ? (~b_reg + 1'b1) : b_reg;
    // Borrow out of the trial subtract means the shifted remainder is below the divisor.
    rem_shift = {rem_reg, quo_reg[WIDTH-1]};
    diff      = rem_shift - {1'b0, dvs_reg};
    q_fix     = qneg_reg ? (~quo_reg + 1'b1) : quo_reg;
    r_fix     = rneg_reg ? (~rem_reg + 1'b1) : rem_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      res_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      done_reg  <= 1'b0;
      dbz_reg   <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sgn_reg   <= 1'b0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      dvs_reg   <= '0;
      qneg_reg  <= 1'b0;
      rneg_reg  <= 1'b0;
      dz_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start && !cancel) begin
            if (is_mul) begin
              res_reg   <= mul_result;
              cnt_reg   <= CW'(MUL_LAT);
              state_reg <= S_MUL;
            end else if (is_div) begin
              a_reg     <= rs;
              b_reg     <= rt;
              sgn_reg   <= (op == OP_DIV);
              state_reg <= S_DIV_PREP;
            end else if (op == OP_MTHI) begin
              hi_reg <= rs;
            end else if (op == OP_MTLO) begin
              lo_reg <= rt;
            end
          end
        end
        S_MUL: begin
          if (cancel) begin
            state_reg <= S_IDLE;
          end else if (cnt_reg == CW'(1)) begin
            {hi_reg, lo_reg} <= res_reg;
            done_reg         <= 1'b1;
            state_reg        <= S_IDLE;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        S_DIV_PREP: begin
          if (cancel) begin
            state_reg <= S_IDLE;
          end else begin
            quo_reg   <= abs_a;
            rem_reg   <= '0;
            dvs_reg   <= abs_b;
            qneg_reg  <= a_neg ^ b_neg;
            rneg_reg  <= a_neg;
            dz_reg    <= (b_reg == '0);
            cnt_reg   <= CW'(WIDTH);
            state_reg <= S_DIV_ITER;
          end
        end
        S_DIV_ITER: begin
          if (cancel) begin
            state_reg <= S_IDLE;
          end else begin
            quo_reg <= {quo_reg[WIDTH-2:0], ~diff[WIDTH]};
            rem_reg <= diff[WIDTH] ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];
            cnt_reg <= cnt_reg - CW'(1);
            if (cnt_reg == CW'(1)) state_reg <= S_DIV_FIX;
          end
        end
        S_DIV_FIX: begin
          if (cancel) begin
            state_reg <= S_IDLE;
          end else begin
            // Divide by zero returns the raw dividend regardless of signedness.
            if (dz_reg) begin
              lo_reg <= '1;
              hi_reg <= a_reg;
            end else begin
              lo_reg <= q_fix;
              hi_reg <= r_fix;
            end
            dbz_reg   <= dz_reg;
            done_reg  <= 1'b1;
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign busy = (state_reg != S_IDLE);
  assign done = done_reg;
  assign dbz  = dbz_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit: directed test-plan cases plus randomized ops,
// compared every cycle against an arithmetic reference model.
module tb_md_unit;
  localparam int W    = 32;
  localparam int LAT  = 5;
  localparam int DLAT = W + 2;

  logic         clk    = 1'b0;
  logic         reset  = 1'b0;
  logic [W-1:0] rs     = '0;
  logic [W-1:0] rt     = '0;
  logic [3:0]   op     = '0;
  logic         start  = 1'b0;
  logic         cancel = 1'b0;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit cmp_en    = 1'b0;

  md_unit #(.WIDTH(W), .MUL_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .rs(rs), .rt(rt), .op(op),
    .start(start), .cancel(cancel), .busy(busy), .done(done),
    .dbz(dbz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: results from plain 64-bit arithmetic, timing as a countdown.
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic         m_dbz = 1'b0, m_done = 1'b0, p_dbz = 1'b0, p_div = 1'b0;
  int           m_rem = 0;

  function automatic logic [63:0] mul_ref(input logic [3:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [63:0] acc);
    longint          sp;
    longint unsigned up;
    logic [63:0]     p;
    if (o inside {4'd1, 4'd5, 4'd7}) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      p  = sp;
    end else begin
      up = {32'b0, a} * {32'b0, b};
      p  = up;
    end
    case (o)
      4'd5, 4'd6: return acc + p;
      4'd7, 4'd8: return acc - p;
      default:    return p;
    endcase
  endfunction

  task automatic div_ref(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] qh, output logic [W-1:0] ql, output logic z);
    longint sa, sb, q, r;
    if (b == '0) begin
      ql = '1; qh = a; z = 1'b1;
    end else begin
      z = 1'b0;
      if (sgn) begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
      end else begin
        sa = longint'({32'b0, a}); sb = longint'({32'b0, b});
      end
      q  = sa / sb;
      r  = sa % sb;
      ql = q[W-1:0];
      qh = r[W-1:0];
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi = '0; m_lo = '0; m_dbz = 1'b0; m_done = 1'b0; m_rem = 0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        if (cancel) m_rem = 0;
        else begin
          m_rem--;
          if (m_rem == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
            if (p_div) m_dbz = p_dbz;
          end
        end
      end else if (start && !cancel) begin
        case (op)
          4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8: begin
            {p_hi, p_lo} = mul_ref(op, rs, rt, {m_hi, m_lo});
            p_div = 1'b0; m_rem = LAT;
          end
          4'd3, 4'd4: begin
            div_ref(op == 4'd3, rs, rt, p_hi, p_lo, p_dbz);
            p_div = 1'b1; m_rem = DLAT;
          end
          4'd9:  m_hi = rs;
          4'd10: m_lo = rt;
          default: ;
        endcase
        $display("txn op=%0d rs=%h rt=%h -> hi=%h lo=%h", op, rs, rt,
                 (m_rem > 0) ? p_hi : m_hi, (m_rem > 0) ? p_lo : m_lo);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", 64'(busy), 64'(m_rem > 0));
      check("done", 64'(done), 64'(m_done));
      check("dbz",  64'(dbz),  64'(m_dbz));
      check("hi",   64'(hi),   64'(m_hi));
      check("lo",   64'(lo),   64'(m_lo));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op = o; rs = a; rt = b; start = 1'b1;
    tick();
    start = 1'b0; op = '0;
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check({name, " latency"}, 64'(n), 64'(exp_lat));
    check({name, " done"}, 64'(done), 64'd1);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return 32'd1;
      2:       return '1;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset hi",   64'(hi),   64'd0);
    check("reset lo",   64'(lo),   64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset dbz",  64'(dbz),  64'd0);
    #2 reset = 1'b1;
    cmp_en = 1'b1;
    tick();

    issue(4'd1, 32'hFFFF_FFFF, 32'd2);
    check("mult busy", 64'(busy), 64'd1);
    wait_done("mult", LAT);
    check("mult hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult lo", 64'(lo), 64'hFFFF_FFFE);
    issue(4'd2, 32'hFFFF_FFFF, 32'd2);
    check("done one cycle", 64'(done), 64'd0);
    check("back-to-back busy", 64'(busy), 64'd1);
    wait_done("multu", LAT);
    check("multu hi", 64'(hi), 64'h0000_0001);
    check("multu lo", 64'(lo), 64'hFFFF_FFFE);

    issue(4'd3, -32'sd7, 32'd2);
    wait_done("div", DLAT);
    check("div lo",  64'(lo),  64'hFFFF_FFFD);
    check("div hi",  64'(hi),  64'hFFFF_FFFF);
    check("div dbz", 64'(dbz), 64'd0);

    issue(4'd4, 32'd100, 32'd0);
    wait_done("divu0", DLAT);
    check("divu0 lo",  64'(lo),  64'hFFFF_FFFF);
    check("divu0 hi",  64'(hi),  64'h0000_0064);
    check("divu0 dbz", 64'(dbz), 64'd1);
    issue(4'd4, 32'd9, 32'd3);
    wait_done("divu", DLAT);
    check("divu lo",  64'(lo),  64'd3);
    check("divu hi",  64'(hi),  64'd0);
    check("divu dbz", 64'(dbz), 64'd0);

    issue(4'd9, 32'd0, 32'd0);
    check("mthi hi", 64'(hi), 64'd0);
    check("mthi busy", 64'(busy), 64'd0);
    issue(4'd10, 32'd0, 32'hFFFF_FFFF);
    check("mtlo lo", 64'(lo), 64'hFFFF_FFFF);
    issue(4'd5, 32'd1, 32'd1);
    wait_done("madd", LAT);
    check("madd hi", 64'(hi), 64'd1);
    check("madd lo", 64'(lo), 64'd0);
    issue(4'd7, 32'd2, 32'd1);
    wait_done("msub", LAT);
    check("msub hi", 64'(hi), 64'd0);
    check("msub lo", 64'(lo), 64'hFFFF_FFFE);

    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div ovf", DLAT);
    check("div ovf lo", 64'(lo), 64'h8000_0000);
    check("div ovf hi", 64'(hi), 64'd0);
    issue(4'd3, -32'sd5, 32'd0);
    wait_done("div0 signed", DLAT);
    check("div0 signed lo",  64'(lo),  64'hFFFF_FFFF);
    check("div0 signed hi",  64'(hi),  64'hFFFF_FFFB);
    check("div0 signed dbz", 64'(dbz), 64'd1);

    issue(4'd3, 32'd100, 32'd7);
    repeat (3) tick();
    op = 4'd9; rs = 32'h1234; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel busy", 64'(busy), 64'd0);
    check("cancel done", 64'(done), 64'd0);
    check("cancel hi",   64'(hi),   64'hFFFF_FFFB);
    check("cancel lo",   64'(lo),   64'hFFFF_FFFF);
    check("cancel dbz",  64'(dbz),  64'd1);
    repeat (40) tick();
    check("cancel no late write", 64'(hi), 64'hFFFF_FFFB);
    op = 4'd10; rt = 32'd0; start = 1'b1; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0;
    check("cancel beats mtlo", 64'(lo), 64'hFFFF_FFFF);

    issue(4'd1, 32'd3, 32'd5);
    tick();
    #2 reset = 1'b0;
    #1;
    check("async rst hi",   64'(hi),   64'd0);
    check("async rst lo",   64'(lo),   64'd0);
    check("async rst busy", 64'(busy), 64'd0);
    #2 reset = 1'b1;
    tick();
    repeat (10) tick();
    check("post rst busy", 64'(busy), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      start  = ($urandom_range(0, 3) == 0);
      cancel = ($urandom_range(0, 24) == 0);
      op     = 4'($urandom_range(0, 12));
      rs     = pick();
      rt     = pick();
      tick();
    end
    start = 1'b0; cancel = 1'b0;
    repeat (40) tick();
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
